// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - 4-digit multiplexed 7-segment scanner for the ALU BCD result.
// Shadow/display double buffer swaps only at frame boundaries so digits never tear mid-frame.
module bcd_display_scanner #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [11:0] bcd,
  input  logic        error,
  input  logic        overflow,
  input  logic        carry_out,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam logic [15:0] TICK_MAX = 16'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_O     = 7'b0100011;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Register layout: {error, overflow, carry_out, bcd[11:0]}
  logic [15:0] tick_q, tick_d;
  logic [1:0]  idx_q, idx_d;
  logic [14:0] shadow_q, shadow_d;
  logic [14:0] disp_q, disp_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        slot_end;
  logic        frame_end;
  logic [3:0]  nib;
  logic        lead_zero;

  function automatic logic [6:0] digit_seg(input logic [3:0] n);
    case (n)
      4'd0:    digit_seg = 7'b1000000;
      4'd1:    digit_seg = 7'b1111001;
      4'd2:    digit_seg = 7'b0100100;
      4'd3:    digit_seg = 7'b0110000;
      4'd4:    digit_seg = 7'b0011001;
      4'd5:    digit_seg = 7'b0010010;
      4'd6:    digit_seg = 7'b0000010;
      4'd7:    digit_seg = 7'b1111000;
      4'd8:    digit_seg = 7'b0000000;
      4'd9:    digit_seg = 7'b0010000;
      default: digit_seg = SEG_DASH;
    endcase
  endfunction

  assign slot_end  = (tick_q == TICK_MAX);
  assign frame_end = slot_end && (idx_q == 2'd3);

  always_comb begin
    tick_d   = slot_end ? 16'd0 : tick_q + 16'd1;
    idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
    shadow_d = load ? {error, overflow, carry_out, bcd} : shadow_q;
    // Display takes the pre-load shadow when load and frame end coincide.
    disp_d   = frame_end ? shadow_q : disp_q;
    an_d     = (tick_q == 16'd0) ? 4'b1111 : ~(4'b0001 << idx_q);

    case (idx_q)
      2'd1:    nib = disp_q[7:4];
      2'd2:    nib = disp_q[11:8];
      default: nib = disp_q[3:0];
    endcase

    case (idx_q)
      2'd1:    lead_zero = (disp_q[11:4] == 8'd0);
      2'd2:    lead_zero = (disp_q[11:8] == 4'd0);
      default: lead_zero = 1'b0;
    endcase

    seg_d = SEG_BLANK;
    if (disp_q[14]) begin
      case (idx_q)
        2'd2:    seg_d = SEG_E;
        2'd3:    seg_d = SEG_BLANK;
        default: seg_d = SEG_R;
      endcase
    end else if (idx_q == 2'd3) begin
      if (disp_q[13])      seg_d = SEG_O;
      else if (disp_q[12]) seg_d = SEG_C;
      else                 seg_d = SEG_BLANK;
    end else if (nib > 4'd9) begin
      seg_d = SEG_DASH;
    end else if (lead_zero) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = digit_seg(nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q   <= 16'd0;
      idx_q    <= 2'd0;
      shadow_q <= 15'd0;
      disp_q   <= 15'd0;
      seg_q    <= SEG_BLANK;
      an_q     <= 4'b1111;
    end else begin
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_end;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - randomized bench with a cycle-count reference model.
// Model derives slot/digit from elapsed cycles and digit content from character rules.
module tb_bcd_display_scanner;
  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  localparam int CH_E = 10, CH_R = 11, CH_DASH = 12, CH_C = 13, CH_O = 14, CH_BL = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [11:0] bcd = 12'd0;
  logic        error = 1'b0, overflow = 1'b0, carry_out = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int n_chk = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  int          m_n;
  logic [14:0] m_shadow, m_disp;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;

  logic [6:0]  cap [4];
  int          lows [4];
  logic [3:0]  an_seq [FRAME];

  bcd_display_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd(bcd), .error(error),
    .overflow(overflow), .carry_out(carry_out), .seg(seg), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] enc(input int ch);
    case (ch)
      0: enc = 7'b1000000;  1: enc = 7'b1111001;  2: enc = 7'b0100100;
      3: enc = 7'b0110000;  4: enc = 7'b0011001;  5: enc = 7'b0010010;
      6: enc = 7'b0000010;  7: enc = 7'b1111000;  8: enc = 7'b0000000;
      9: enc = 7'b0010000;  CH_E: enc = 7'b0000110; CH_R: enc = 7'b0101111;
      CH_DASH: enc = 7'b0111111; CH_C: enc = 7'b1000110; CH_O: enc = 7'b0100011;
      default: enc = 7'b1111111;
    endcase
  endfunction

  function automatic int want_char(input logic [14:0] v, input int d);
    int val, nibv;
    val = int'(v[11:0]);
    if (v[14]) return (d == 3) ? CH_BL : (d == 2) ? CH_E : CH_R;
    if (d == 3) return v[13] ? CH_O : v[12] ? CH_C : CH_BL;
    nibv = (val >> (4 * d)) & 15;
    if (nibv > 9) return CH_DASH;
    if (d > 0 && (val >> (4 * d)) == 0) return CH_BL;
    return nibv;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_shadow = '0; m_disp = '0;
      e_seg = 7'h7F; e_an = 4'hF;
    end else begin
      int tk, ix;
      tk = m_n % DIV;
      ix = (m_n / DIV) % 4;
      e_an  = (tk == 0) ? 4'hF : ~(4'b0001 << ix);
      e_seg = enc(want_char(m_disp, ix));
      if (m_n % FRAME == FRAME - 1) m_disp = m_shadow;
      if (load) m_shadow = {error, overflow, carry_out, bcd};
      m_n++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("seg", {25'd0, seg}, {25'd0, e_seg});
      chk("an", {28'd0, an}, {28'd0, e_an});
      chk("frame_done", {31'd0, frame_done}, {31'd0, (m_n % FRAME) == FRAME - 1});
    end
  end

  task automatic wait_fd();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_done && k < 3 * FRAME);
    if (!frame_done) chk("frame_done_timeout", 0, 1);
  endtask

  // Expects to be entered at the negedge of the first cycle of a frame.
  task automatic capture();
    for (int d = 0; d < 4; d++) begin cap[d] = 7'h7F; lows[d] = 0; end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      an_seq[i] = an;
      for (int d = 0; d < 4; d++)
        if (an[d] == 1'b0) begin cap[d] = seg; lows[d]++; end
    end
  endtask

  task automatic check_frame(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                             input logic [6:0] d1, input logic [6:0] d0);
    chk({tag, "_d3"}, {25'd0, cap[3]}, {25'd0, d3});
    chk({tag, "_d2"}, {25'd0, cap[2]}, {25'd0, d2});
    chk({tag, "_d1"}, {25'd0, cap[1]}, {25'd0, d1});
    chk({tag, "_d0"}, {25'd0, cap[0]}, {25'd0, d0});
  endtask

  task automatic do_load(input logic [11:0] v, input logic e, input logic o, input logic c);
    @(negedge clk);
    bcd = v; error = e; overflow = o; carry_out = c; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bcd = 12'($urandom); error = 1'($urandom); overflow = 1'($urandom); carry_out = 1'($urandom);
  endtask

  task automatic show_next();
    wait_fd();
    @(negedge clk);
    capture();
  endtask

  initial begin
    int cnt;
    #12;
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_fd", {31'd0, frame_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Idle scan after reset
    show_next();
    check_frame("idle", 7'h7F, 7'h7F, 7'h7F, 7'h40);
    for (int d = 0; d < 4; d++) chk("anode_low_cycles", lows[d], 3);
    chk("an_seq0", {28'd0, an_seq[0]}, 32'hF);
    chk("an_seq1", {28'd0, an_seq[1]}, 32'hE);
    chk("an_seq5", {28'd0, an_seq[5]}, 32'hD);
    chk("an_seq9", {28'd0, an_seq[9]}, 32'hB);
    chk("an_seq13", {28'd0, an_seq[13]}, 32'h7);
    wait_fd();
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!frame_done && cnt < 3 * FRAME);
    chk("fd_period", cnt, FRAME);

    do_load(12'h255, 0, 0, 0);
    show_next();
    check_frame("v255", 7'h7F, 7'h24, 7'h12, 7'h12);

    do_load(12'h007, 0, 0, 1);
    show_next();
    check_frame("v007c", 7'h46, 7'h7F, 7'h7F, 7'h78);
    do_load(12'h007, 0, 1, 1);
    show_next();
    check_frame("v007o", 7'h23, 7'h7F, 7'h7F, 7'h78);

    do_load(12'h123, 1, 0, 0);
    show_next();
    check_frame("err", 7'h7F, 7'h06, 7'h2F, 7'h2F);
    do_load(12'h0A3, 0, 0, 0);
    show_next();
    check_frame("v0A3", 7'h7F, 7'h7F, 7'h3F, 7'h30);

    // Load coinciding with the frame boundary
    wait_fd();
    bcd = 12'h111; error = 0; overflow = 0; carry_out = 0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    capture();
    check_frame("coinc_old", 7'h7F, 7'h7F, 7'h3F, 7'h30);
    capture();
    check_frame("coinc_new", 7'h7F, 7'h79, 7'h79, 7'h79);

    // Asynchronous reset mid-slot with a pending load
    repeat (6) @(negedge clk);
    bcd = 12'h999; load = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", {25'd0, seg}, 32'h7F);
    chk("async_rst_an", {28'd0, an}, 32'hF);
    load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    show_next();
    check_frame("post_rst", 7'h7F, 7'h7F, 7'h7F, 7'h40);

    // Random loads; the per-cycle compare process does the checking
    for (int k = 0; k < 80; k++) begin
      logic [11:0] rv;
      rv = ($urandom_range(0, 3) == 0) ? 12'($urandom) :
           {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 2) == 0) rv = rv & 12'h00F;
      do_load(rv, ($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    repeat (2 * FRAME) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
